// File: rtl/fetch_reg_r_pkg.sv
// Shared CPU fetch definitions: PC stepping, reset address, buffer sizing and entry payload.
package fetch_reg_r_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned BUF_DEPTH = 2;
    localparam int unsigned CNT_W     = 2;
    localparam int unsigned PTR_W     = 1;
    localparam int unsigned OCC_W     = 3;

    localparam logic [XLEN-1:0] PC_STEP          = 32'd4;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    // Force an address onto a word boundary.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/fetch_reg_r_if.sv
// Fetch-stage bundle: decode handshake, execute redirect and instruction-memory port.
interface fetch_reg_r_if;
    import fetch_reg_r_pkg::*;

    logic            stall_i;
    logic            branch_en_i;
    logic [XLEN-1:0] branch_target_i;
    logic            imem_req_o;
    logic [XLEN-1:0] imem_addr_o;
    logic [XLEN-1:0] imem_data_i;
    logic            valid_o;
    logic [XLEN-1:0] pc_o;
    logic [XLEN-1:0] inst_o;

    modport master (
        input  stall_i,
        input  branch_en_i,
        input  branch_target_i,
        input  imem_data_i,
        output imem_req_o,
        output imem_addr_o,
        output valid_o,
        output pc_o,
        output inst_o
    );

    modport slave (
        output stall_i,
        output branch_en_i,
        output branch_target_i,
        output imem_data_i,
        input  imem_req_o,
        input  imem_addr_o,
        input  valid_o,
        input  pc_o,
        input  inst_o
    );

endinterface

// File: rtl/fetch_reg_r_fetch_buffer.sv
// Two-entry {pc, inst} FIFO with synchronous clear; head entry is read straight from storage.
module fetch_buffer
    import fetch_reg_r_pkg::*;
(
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             enq_i,
    input  logic             deq_i,
    input  fetch_entry_t     enq_data_i,
    output logic [CNT_W-1:0] count_o,
    output fetch_entry_t     head_o
);

    fetch_entry_t     mem_q [BUF_DEPTH];
    logic [PTR_W-1:0] head_q;
    logic [CNT_W-1:0] count_q;
    logic [PTR_W-1:0] tail_c;

    // Tail wraps modulo depth; a full buffer never sees an enqueue.
    assign tail_c = head_q + PTR_W'(count_q);

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            head_q  <= '0;
            count_q <= '0;
        end else begin
            if (deq_i) begin
                head_q <= head_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(enq_i) - CNT_W'(deq_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq_i && !clr_i) begin
            mem_q[tail_c] <= enq_data_i;
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[head_q];

endmodule

// File: rtl/fetch_reg_r.sv
// Instruction-fetch stage: owns the PC, issues credit-limited imem reads and
// buffers returns so decode stalls never drop or duplicate instructions.
module fetch_reg_r
    import fetch_reg_r_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic          clk_i,
    input  logic          reset_i,
    fetch_reg_r_if.master bus
);

    logic [XLEN-1:0]  fetch_pc_q;
    logic             pend_v_q;
    logic [XLEN-1:0]  pend_pc_q;

    logic [CNT_W-1:0] buf_count;
    fetch_entry_t     buf_head;
    fetch_entry_t     buf_enq_data;

    logic             valid_c;
    logic             deq_c;
    logic [OCC_W-1:0] occ_c;
    logic             issue_c;
    logic             redirect_c;
    logic [XLEN-1:0]  branch_addr_c;
    logic             buf_clr_c;

    // Credit check: entries held plus in flight, after this cycle's dequeue, must leave room.
    always_comb begin
        branch_addr_c = word_align(bus.branch_target_i);
        valid_c       = !reset_i && (buf_count != '0);
        deq_c         = valid_c && !bus.stall_i;
        occ_c         = OCC_W'(buf_count) + OCC_W'(pend_v_q) - OCC_W'(deq_c);
        issue_c       = occ_c < OCC_W'(BUF_DEPTH);
        redirect_c    = bus.branch_en_i && !reset_i;
        buf_clr_c     = reset_i || bus.branch_en_i;
        buf_enq_data  = '{pc: pend_pc_q, inst: bus.imem_data_i};
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fetch_pc_q <= RESET_PC;
            pend_v_q   <= 1'b0;
            pend_pc_q  <= RESET_PC;
        end else if (bus.branch_en_i) begin
            fetch_pc_q <= branch_addr_c + PC_STEP;
            pend_v_q   <= 1'b1;
            pend_pc_q  <= branch_addr_c;
        end else if (issue_c) begin
            fetch_pc_q <= fetch_pc_q + PC_STEP;
            pend_v_q   <= 1'b1;
            pend_pc_q  <= fetch_pc_q;
        end else begin
            pend_v_q   <= 1'b0;
        end
    end

    fetch_buffer u_fetch_buffer (
        .clk_i      (clk_i),
        .clr_i      (buf_clr_c),
        .enq_i      (pend_v_q),
        .deq_i      (deq_c),
        .enq_data_i (buf_enq_data),
        .count_o    (buf_count),
        .head_o     (buf_head)
    );

    assign bus.imem_req_o  = !reset_i && (redirect_c || issue_c);
    assign bus.imem_addr_o = redirect_c ? branch_addr_c : fetch_pc_q;
    assign bus.valid_o     = valid_c;
    assign bus.pc_o        = buf_head.pc;
    assign bus.inst_o      = buf_head.inst;

endmodule

// File: tb/tb_fetch_reg_r.sv
// Bench for fetch_reg_r: directed vector table plus randomized run against a queue-based model.
module tb_fetch_reg_r;

    localparam logic [31:0] KEY      = 32'hA5A5_A5A5;
    localparam logic [31:0] RST_PC   = 32'h0000_0000;
    localparam int          N_RANDOM = 800;

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic        rst;
        logic        ev;
        logic [31:0] epc;
        logic        ereq;
        logic [31:0] eaddr;
    } vec_t;

    logic clk_i = 1'b0;
    logic reset_i;
    always #5 clk_i = ~clk_i;

    fetch_reg_r_if bus ();

    fetch_reg_r #(.RESET_PC(RST_PC)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    // Synchronous instruction memory: data one cycle after the request, junk otherwise.
    always_ff @(posedge clk_i) begin
        if (bus.imem_req_o) bus.imem_data_i <= bus.imem_addr_o ^ KEY;
        else                bus.imem_data_i <= $urandom;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model state: what fetch is owed, expressed as a queue of PCs.
    logic [31:0] m_q[$];
    logic [31:0] m_fetch = RST_PC;
    bit          m_pend  = 1'b0;
    logic [31:0] m_pend_pc = 32'h0;

    vec_t tab[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic st, input logic br, input logic [31:0] tgt,
                                input logic rst, input logic ev, input logic [31:0] epc,
                                input logic ereq, input logic [31:0] eaddr);
        vec_t v;
        v.stall = st; v.br = br; v.tgt = tgt; v.rst = rst;
        v.ev = ev; v.epc = epc; v.ereq = ereq; v.eaddr = eaddr;
        return v;
    endfunction

    task automatic run_cycle(input vec_t v, input bit use_tab);
        bit          mv;
        bit          mdeq;
        bit          mreq;
        int          occ;
        logic [31:0] maddr;
        logic [31:0] aligned;
        bus.stall_i         = v.stall;
        bus.branch_en_i     = v.br;
        bus.branch_target_i = v.tgt;
        reset_i             = v.rst;
        #4;
        aligned = v.tgt & 32'hFFFF_FFFC;
        mv   = !v.rst && (m_q.size() > 0);
        mdeq = mv && !v.stall;
        occ  = m_q.size() + int'(m_pend) - int'(mdeq);
        mreq = v.rst ? 1'b0 : (v.br ? 1'b1 : (occ < 2));
        maddr = v.br ? aligned : m_fetch;

        chk("mdl_valid", 32'(bus.valid_o), 32'(mv));
        if (mv) begin
            chk("mdl_pc", bus.pc_o, m_q[0]);
            chk("mdl_inst", bus.inst_o, m_q[0] ^ KEY);
        end
        chk("mdl_req", 32'(bus.imem_req_o), 32'(mreq));
        if (mreq) chk("mdl_addr", bus.imem_addr_o, maddr);

        if (use_tab) begin
            chk("tab_valid", 32'(bus.valid_o), 32'(v.ev));
            if (v.ev) begin
                chk("tab_pc", bus.pc_o, v.epc);
                chk("tab_inst", bus.inst_o, v.epc ^ KEY);
            end
            chk("tab_req", 32'(bus.imem_req_o), 32'(v.ereq));
            if (v.ereq) chk("tab_addr", bus.imem_addr_o, v.eaddr);
        end

        if (v.rst) begin
            m_q.delete();
            m_fetch = RST_PC;
            m_pend  = 1'b0;
        end else if (v.br) begin
            m_q.delete();
            m_pend    = 1'b1;
            m_pend_pc = aligned;
            m_fetch   = aligned + 32'd4;
        end else begin
            if (mdeq) void'(m_q.pop_front());
            if (m_pend) m_q.push_back(m_pend_pc);
            if (mreq) begin
                m_pend    = 1'b1;
                m_pend_pc = m_fetch;
                m_fetch   = m_fetch + 32'd4;
            end else begin
                m_pend = 1'b0;
            end
        end

        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    initial begin
        vec_t rv;
        reset_i             = 1'b1;
        bus.stall_i         = 1'b0;
        bus.branch_en_i     = 1'b0;
        bus.branch_target_i = 32'h0;

        // stall, br, tgt, rst | valid, pc, req, addr
        tab.push_back(mk(0, 0, 32'h0, 1, 0, 32'h0, 0, 32'h0));
        tab.push_back(mk(0, 0, 32'h0, 1, 0, 32'h0, 0, 32'h0));
        tab.push_back(mk(0, 0, 32'h0, 0, 0, 32'h0, 1, 32'h0));
        tab.push_back(mk(0, 0, 32'h0, 0, 0, 32'h0, 1, 32'h4));
        tab.push_back(mk(0, 0, 32'h0, 0, 1, 32'h0, 1, 32'h8));
        tab.push_back(mk(0, 0, 32'h0, 0, 1, 32'h4, 1, 32'hC));
        for (int i = 0; i < 5; i++)
            tab.push_back(mk(1, 0, 32'h0, 0, 1, 32'h8, 0, 32'h0));
        tab.push_back(mk(0, 0, 32'h0, 0, 1, 32'h8,  1, 32'h10));
        tab.push_back(mk(0, 0, 32'h0, 0, 1, 32'hC,  1, 32'h14));
        tab.push_back(mk(0, 0, 32'h0, 0, 1, 32'h10, 1, 32'h18));
        tab.push_back(mk(0, 1, 32'h103, 0, 1, 32'h14, 1, 32'h100));
        tab.push_back(mk(0, 0, 32'h0, 0, 0, 32'h0,   1, 32'h104));
        tab.push_back(mk(0, 0, 32'h0, 0, 1, 32'h100, 1, 32'h108));
        tab.push_back(mk(0, 0, 32'h0, 0, 1, 32'h104, 1, 32'h10C));
        tab.push_back(mk(1, 0, 32'h0, 0, 1, 32'h108, 0, 32'h0));
        tab.push_back(mk(1, 0, 32'h0, 0, 1, 32'h108, 0, 32'h0));
        tab.push_back(mk(1, 1, 32'h200, 0, 1, 32'h108, 1, 32'h200));
        tab.push_back(mk(0, 0, 32'h0, 0, 0, 32'h0,   1, 32'h204));
        tab.push_back(mk(0, 0, 32'h0, 0, 1, 32'h200, 1, 32'h208));
        tab.push_back(mk(0, 0, 32'h0, 0, 1, 32'h204, 1, 32'h20C));
        tab.push_back(mk(0, 1, 32'hFFFF_FFFE, 0, 1, 32'h208, 1, 32'hFFFF_FFFC));
        tab.push_back(mk(0, 0, 32'h0, 0, 0, 32'h0,         1, 32'h0));
        tab.push_back(mk(0, 0, 32'h0, 0, 1, 32'hFFFF_FFFC, 1, 32'h4));
        tab.push_back(mk(0, 0, 32'h0, 0, 1, 32'h0, 1, 32'h8));
        tab.push_back(mk(0, 0, 32'h0, 0, 1, 32'h4, 1, 32'hC));
        tab.push_back(mk(0, 0, 32'h0, 1, 0, 32'h0, 0, 32'h0));
        tab.push_back(mk(0, 0, 32'h0, 0, 0, 32'h0, 1, 32'h0));
        tab.push_back(mk(0, 0, 32'h0, 0, 0, 32'h0, 1, 32'h4));
        tab.push_back(mk(0, 0, 32'h0, 0, 1, 32'h0, 1, 32'h8));

        @(posedge clk_i);
        #1;
        foreach (tab[i]) run_cycle(tab[i], 1'b1);

        for (int i = 0; i < N_RANDOM; i++) begin
            rv = mk(($urandom % 3) == 0, ($urandom % 16) == 0, $urandom,
                    ($urandom % 64) == 0, 0, 32'h0, 0, 32'h0);
            run_cycle(rv, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
